// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store sequencer and its lane-alignment helper.
//   - XLEN / REG_AW       : data/address width and register index width
//   - SZ_*                : op_size encodings
//   - ST_*                : sequencer FSM state encodings
//   - op_t                : op fields latched at accept time
//   - sext_imm()          : sign-extend the 12-bit offset to XLEN
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Access size encodings; 2'b11 is reserved and always rejected.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  // Everything the sequencer needs to remember about the op in flight.
  typedef struct packed {
    logic              is_store;
    logic [1:0]        size;
    logic              uns;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [11:0]       imm;
  } op_t;

  function automatic logic [XLEN-1:0] sext_imm(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane helper for the load/store sequencer.
// Ports:
//   size_i        access size (SZ_B/SZ_H/SZ_W, 2'b11 illegal)
//   unsigned_i    loads: zero-extend instead of sign-extend
//   offset_i      byte offset within the word (ea[1:0])
//   rs2_value_i   store data register value
//   mem_rdata_i   raw word returned by memory
//   mem_be_o      byte enables for the access
//   mem_wdata_o   store data replicated onto every lane
//   load_result_o addressed lane, extended to XLEN
//   misaligned_o  access cannot be issued (bad alignment or illegal size)
// -----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] rs2_value_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [XLEN-1:0] load_result_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] lane_s;

  // Shift the addressed lane down to bit 0 (little-endian byte order).
  always_comb begin
    lane_s = mem_rdata_i >> {offset_i, 3'b000};
  end

  // Byte enables, store replication, load extension and legality per size.
  always_comb begin
    mem_be_o      = 4'b0000;
    mem_wdata_o   = {XLEN{1'b0}};
    load_result_o = {XLEN{1'b0}};
    misaligned_o  = 1'b0;
    case (size_i)
      SZ_B: begin
        mem_be_o     = 4'b0001 << offset_i;
        mem_wdata_o  = {4{rs2_value_i[7:0]}};
        misaligned_o = 1'b0;
        if (unsigned_i) begin
          load_result_o = {24'h000000, lane_s[7:0]};
        end else begin
          load_result_o = {{24{lane_s[7]}}, lane_s[7:0]};
        end
      end
      SZ_H: begin
        mem_be_o     = 4'b0011 << offset_i;
        mem_wdata_o  = {2{rs2_value_i[15:0]}};
        misaligned_o = offset_i[0];
        if (unsigned_i) begin
          load_result_o = {16'h0000, lane_s[15:0]};
        end else begin
          load_result_o = {{16{lane_s[15]}}, lane_s[15:0]};
        end
      end
      SZ_W: begin
        mem_be_o      = 4'b1111;
        mem_wdata_o   = rs2_value_i;
        load_result_o = mem_rdata_i;
        misaligned_o  = |offset_i;
      end
      default: begin
        // Reserved size: never issued, reported as an error.
        mem_be_o      = 4'b0000;
        mem_wdata_o   = {XLEN{1'b0}};
        load_result_o = {XLEN{1'b0}};
        misaligned_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu_regfile_sequencer.sv
// -----------------------------------------------------------------------------
// lsu_regfile_sequencer
// Accepts one load/store op at a time from decode, reads base and store-data
// registers, forms the effective address, runs one req/gnt/rvalid memory
// transaction and writes load results back to the register array.
// Misaligned or illegal ops are rejected with err/err_addr and no side effects.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   op_valid/op_ready                  decode handshake (ready only in IDLE)
//   op_is_store, op_size, op_unsigned  op kind, size, load extension
//   op_rs1, op_rs2, op_rd, op_imm      register indices and signed offset
//   rf_rs1, rf_rs2, rf_rs1_value, rf_rs2_value   register read port
//   rf_rd, rf_wdata, rf_wer            register write port (one-cycle pulse)
//   mem_req/mem_gnt, mem_we, mem_addr, mem_wdata, mem_be   request channel
//   mem_rvalid, mem_rdata              read response channel
//   done, err, err_addr                completion / rejection reporting
// -----------------------------------------------------------------------------
module lsu_regfile_sequencer
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_is_store,
  input  logic [1:0]        op_size,
  input  logic              op_unsigned,
  input  logic [REG_AW-1:0] op_rs1,
  input  logic [REG_AW-1:0] op_rs2,
  input  logic [REG_AW-1:0] op_rd,
  input  logic [11:0]       op_imm,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  input  logic [XLEN-1:0]   rf_rs1_value,
  input  logic [XLEN-1:0]   rf_rs2_value,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              rf_wer,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              done,
  output logic              err,
  output logic [XLEN-1:0]   err_addr
);

  logic [1:0]      state_q,     state_d;
  op_t             op_q,        op_d;
  logic [1:0]      off_q,       off_d;
  logic [XLEN-1:0] rf_wdata_q,  rf_wdata_d;
  logic            rf_wer_q,    rf_wer_d;
  logic            mem_req_q,   mem_req_d;
  logic            mem_we_q,    mem_we_d;
  logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_be_q,    mem_be_d;
  logic            done_q,      done_d;
  logic            err_q,       err_d;
  logic [XLEN-1:0] err_addr_q,  err_addr_d;

  logic [XLEN-1:0] ea_s;
  logic [1:0]      align_off_s;
  logic [3:0]      be_s;
  logic [XLEN-1:0] wdata_s;
  logic [XLEN-1:0] load_result_s;
  logic            misaligned_s;

  // Effective address is formed from the live register read in READ; the
  // aligner sees that offset in READ and the captured offset afterwards.
  always_comb begin
    ea_s = rf_rs1_value + sext_imm(op_q.imm);
    if (state_q == ST_READ) begin
      align_off_s = ea_s[1:0];
    end else begin
      align_off_s = off_q;
    end
  end

  lsu_lane_align u_align (
    .size_i        (op_q.size),
    .unsigned_i    (op_q.uns),
    .offset_i      (align_off_s),
    .rs2_value_i   (rf_rs2_value),
    .mem_rdata_i   (mem_rdata),
    .mem_be_o      (be_s),
    .mem_wdata_o   (wdata_s),
    .load_result_o (load_result_s),
    .misaligned_o  (misaligned_s)
  );

  // Next-state and output-register logic for the IDLE/READ/REQ/WAIT sequence.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    rf_wdata_d  = rf_wdata_q;
    rf_wer_d    = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_addr_d  = err_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          op_d.is_store = op_is_store;
          op_d.size     = op_size;
          op_d.uns      = op_unsigned;
          op_d.rs1      = op_rs1;
          op_d.rs2      = op_rs2;
          op_d.rd       = op_rd;
          op_d.imm      = op_imm;
          state_d       = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        off_d = ea_s[1:0];
        if (misaligned_s) begin
          // Rejected: report and return without touching memory or registers.
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_addr_d = ea_s;
        end else begin
          // Request fields are registered here so they hold through any stall.
          state_d     = ST_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = op_q.is_store;
          mem_addr_d  = {ea_s[XLEN-1:2], 2'b00};
          mem_be_d    = be_s;
          mem_wdata_d = wdata_s;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (op_q.is_store) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          mem_req_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          rf_wdata_d = load_result_s;
          // x0 is hardwired: the load completes but nothing is written.
          rf_wer_d   = (op_q.rd != {REG_AW{1'b0}});
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      off_q       <= 2'b00;
      rf_wdata_q  <= {XLEN{1'b0}};
      rf_wer_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {XLEN{1'b0}};
      mem_wdata_q <= {XLEN{1'b0}};
      mem_be_q    <= 4'b0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      rf_wdata_q  <= rf_wdata_d;
      rf_wer_q    <= rf_wer_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign op_ready  = (state_q == ST_IDLE);
  assign rf_rs1    = op_q.rs1;
  assign rf_rs2    = op_q.rs2;
  assign rf_rd     = op_q.rd;
  assign rf_wdata  = rf_wdata_q;
  assign rf_wer    = rf_wer_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule
